round_key_pipe: RTL
===================

ROUND_KEY_PIPE -- requirements
Module: round_key_pipe

Interface
REQ-001 Parameter WORDS, default 4: number of 32-bit words per block; data width W = 32*WORDS; legal values 4, 6, 8.
REQ-002 Parameter STAGES, default 2: pipeline depth in register stages; legal values 1 to 4.
REQ-003 Parameter NR, default 10: last round index; legal values 1 to 15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
REQ-006 in_valid  input  1  input block present.
REQ-007 in_ready  output  1  block can accept an input beat this cycle.
REQ-008 data  input  W  state block to be mixed.
REQ-009 key_load  input  1  load key into the key register this cycle.
REQ-010 key  input  W  round key value.
REQ-011 out_valid  output  1  out holds a valid result.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out  output  W  data XOR effective key.
REQ-014 out_round  output  4  round tag of the result on out.
REQ-015 out_last  output  1  high when out_round equals NR.

Function
REQ-016 An input beat is accepted when in_valid and in_ready are both high; an output beat is consumed when out_valid and out_ready are both high.
REQ-017 The key register loads key on any cycle with key_load high, independent of in_valid.
REQ-018 Effective key for an accepted beat: key if key_load is high in the same cycle (bypass), else the key register.
REQ-019 Result: bitwise XOR of data and effective key over all W bits; no other transformation.
REQ-020 Round counter, 4 bits: increments on each accepted beat; wraps from NR to 0; the pre-increment value is the beat's tag.
REQ-021 The tag and result travel together through all STAGES registers; out_round and out_last always belong to the current out value.
REQ-022 Each stage holds one valid bit; a stage advances when the next stage is empty or advancing; the last stage advances when out_ready is high.
REQ-023 in_ready is high when stage 1 is empty or advancing; it is combinational from out_ready through the stage chain and does not depend on in_valid.
REQ-024 Latency without backpressure: a beat accepted in cycle t appears with out_valid in cycle t+STAGES.
REQ-025 Throughput: one beat per cycle while out_ready stays high; no bubbles are inserted.
REQ-026 While stalled (out_valid high and out_ready low), out, out_round and out_last hold stable; no beat is lost or duplicated.
REQ-027 When the pipeline is full and stalled, in_ready is low and the round counter does not advance.
REQ-028 A key_load during a stall updates the key register only; beats already in flight keep their original result.

Reset
REQ-029 While rst is low at a clock edge: all stage valid bits clear, the key register clears to 0, and the round counter clears to 0.
REQ-030 After reset: out_valid 0, out 0, out_round 0, out_last 0; in_ready is 1 from the first cycle after rst is released.
REQ-031 Reset during operation discards all in-flight beats; no partial beat is emitted afterwards.

Verification
REQ-032 The bench shall cover at least the following scenarios:
- WORDS=4, STAGES=2, key_load=1 with data 046681e5_e0cb199a_48f8d37a_2806264c, key a0fafe17_88542cb1_23a33939_2a6c7605, in_valid=1 -> two cycles later out = a49c7ff2_689f352b_6b5bea43_026a5049, out_round = 0, out_last = 0.
- Key loaded once, then 11 back-to-back beats with NR=10 and out_ready=1 -> out_round runs 0 to 10; out_last high only on the 11th beat; the 12th beat is tagged 0.
- Pipeline full with out_ready=0 for 5 cycles -> in_ready=0, out stable, counter frozen; on release, all beats appear in order with none lost.
- key_load with a new key in the same cycle as an accepted beat -> that beat uses the new key; the beat before it keeps the old key.
- rst low for one cycle while 2 beats are in flight -> out_valid=0 next cycle, key register 0, the next accepted beat is tagged 0.
- WORDS=8, STAGES=1, all-ones data XOR all-ones key -> out all zeros one cycle after acceptance.

Source files
------------

// File: rtl/round_key_pipe.sv
// round_key_pipe
//
// Mixes each accepted state block with a round key (plain XOR) and carries
// the result through a valid/ready register pipeline of STAGES stages. Every
// result is tagged with a 4-bit round number taken from a counter that counts
// accepted beats and wraps from NR back to 0.
//
// Parameters:
//   WORDS  - 32-bit words per block (4, 6 or 8); block width W = 32*WORDS
//   STAGES - number of pipeline register stages (1..4)
//   NR     - last round index (1..15)
//
// Ports:
//   clk        clock, all state changes on its rising edge
//   rst        synchronous reset, active low
//   in_valid   input block present
//   in_ready   pipeline can take an input beat this cycle
//   data       state block (W bits)
//   key_load   load key into the key register this cycle
//   key        round key (W bits)
//   out_valid  out carries a valid result
//   out_ready  downstream accepts the result
//   out        data XOR effective key
//   out_round  round tag of the result on out
//   out_last   out_round equals NR
module round_key_pipe #(
    parameter int WORDS  = 4,
    parameter int STAGES = 2,
    parameter int NR     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*WORDS-1:0]   data,
    input  logic                  key_load,
    input  logic [32*WORDS-1:0]   key,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*WORDS-1:0]   out,
    output logic [3:0]            out_round,
    output logic                  out_last
);

    localparam int         W      = 32 * WORDS;
    localparam logic [3:0] NR_TAG = 4'(NR);

    logic [W-1:0]               key_reg;
    logic [3:0]                 round_reg;
    logic [3:0]                 round_next;
    logic                       accept;
    logic [W-1:0]               eff_key;

    logic [STAGES-1:0]          valid_reg;
    logic [STAGES-1:0][W-1:0]   data_reg;
    logic [STAGES-1:0][3:0]     tag_reg;

    // What each stage would load if it is allowed to advance this cycle.
    logic [STAGES-1:0]          valid_in;
    logic [STAGES-1:0][W-1:0]   data_in;
    logic [STAGES-1:0][3:0]     tag_in;

    // load_ok[i]: stage i may take new contents this cycle (it is empty or
    // its contents move on). load_ok[STAGES] stands for the downstream sink.
    logic [STAGES:0]            load_ok;

    always_comb begin
        load_ok         = '0;
        load_ok[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            load_ok[i] = !valid_reg[i] || load_ok[i+1];
        end
    end

    assign in_ready   = load_ok[0];
    assign accept     = in_valid && in_ready;
    // Same-cycle key_load bypasses the key register for the beat being taken.
    assign eff_key    = key_load ? key : key_reg;
    assign round_next = (round_reg == NR_TAG) ? 4'd0 : round_reg + 4'd1;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage_in
            if (gi == 0) begin : g_head
                assign valid_in[gi] = accept;
                assign data_in[gi]  = data ^ eff_key;
                assign tag_in[gi]   = round_reg;
            end else begin : g_body
                assign valid_in[gi] = valid_reg[gi-1];
                assign data_in[gi]  = data_reg[gi-1];
                assign tag_in[gi]   = tag_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_reg <= '0;
            data_reg  <= '0;
            tag_reg   <= '0;
            key_reg   <= '0;
            round_reg <= '0;
        end else begin
            if (key_load) begin
                key_reg <= key;
            end
            if (accept) begin
                round_reg <= round_next;
            end
            for (int i = 0; i < STAGES; i++) begin
                if (load_ok[i]) begin
                    valid_reg[i] <= valid_in[i];
                    // Payload only moves with a real beat, so an idle stage
                    // keeps its last contents instead of picking up garbage.
                    if (valid_in[i]) begin
                        data_reg[i] <= data_in[i];
                        tag_reg[i]  <= tag_in[i];
                    end
                end
            end
        end
    end

    assign out_valid = valid_reg[STAGES-1];
    assign out       = data_reg[STAGES-1];
    assign out_round = tag_reg[STAGES-1];
    assign out_last  = (out_round == NR_TAG);

endmodule
